// File: rtl/sd_rsp_pkg.sv
// Shared constants, state encoding and the serial CRC7 step for the SD CMD-line response receiver.
package sd_rsp_pkg;

    localparam int RspShortBits    = 48;
    localparam int RspLongBits     = 136;
    localparam int PayloadBits     = 120;
    localparam int IdxFirstBit     = 2;
    localparam int PayloadFirstBit = 8;
    localparam logic [6:0] Crc7Poly = 7'h09;

    typedef logic [1:0] rsp_state_e;
    localparam rsp_state_e ST_IDLE       = 2'd0;
    localparam rsp_state_e ST_WAIT_START = 2'd1;
    localparam rsp_state_e ST_RECEIVE    = 2'd2;
    localparam rsp_state_e ST_BUSY       = 2'd3;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
    endfunction

endpackage

// File: rtl/rsp_receiver_if.sv
// Host-side bundle of the response receiver; busy ports exist only with RSP_BUSY_DETECT_EN.
// Handshake: start_i is a one-cycle request taken only in IDLE; rsp_valid_o is a one-cycle completion pulse.
interface rsp_receiver_if;
    import sd_rsp_pkg::*;

    logic                   cmd_i;
    logic                   start_i;
    logic                   long_rsp_i;
    logic                   crc_check_en_i;
    logic                   idx_check_en_i;
    logic [5:0]             cmd_idx_i;
    logic                   abort_i;
    logic                   receiving_o;
    logic                   rsp_valid_o;
    logic [PayloadBits-1:0] rsp_o;
    logic [5:0]             rsp_idx_o;
    logic                   timeout_err_o;
    logic                   crc_err_o;
    logic                   end_bit_err_o;
    logic                   idx_err_o;
    rsp_state_e             state_o;
`ifdef RSP_BUSY_DETECT_EN
    logic                   busy_en_i;
    logic                   dat0_i;
    logic                   busy_o;
`endif

    modport master (
`ifdef RSP_BUSY_DETECT_EN
        output busy_en_i, dat0_i, input busy_o,
`endif
        output cmd_i, start_i, long_rsp_i, crc_check_en_i, idx_check_en_i, cmd_idx_i, abort_i,
        input  receiving_o, rsp_valid_o, rsp_o, rsp_idx_o, timeout_err_o, crc_err_o,
               end_bit_err_o, idx_err_o, state_o
    );

    modport slave (
`ifdef RSP_BUSY_DETECT_EN
        input busy_en_i, dat0_i, output busy_o,
`endif
        input  cmd_i, start_i, long_rsp_i, crc_check_en_i, idx_check_en_i, cmd_idx_i, abort_i,
        output receiving_o, rsp_valid_o, rsp_o, rsp_idx_o, timeout_err_o, crc_err_o,
               end_bit_err_o, idx_err_o, state_o
    );

endinterface

// File: rtl/sd_crc7_gen.sv
// Serial CRC7 (x^7+x^3+1) generator: clear has priority, one bit folded in per enabled cycle.
module sd_crc7_gen
    import sd_rsp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 7'h00;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/rsp_receiver.sv
// SD CMD-line response receiver (48-bit R1/R3/R6/R7, 136-bit R2) with CRC/index checks and Ncr timeout.
// Optional DAT0 busy wait after the end bit is compiled in with RSP_BUSY_DETECT_EN.
module rsp_receiver
    import sd_rsp_pkg::*;
#(
    parameter int TimeoutCycles = 64,
    parameter int WaitCntWidth  = $clog2(TimeoutCycles + 1)
) (
    input logic           sd_clk_i,
    input logic           rst_i,
    rsp_receiver_if.slave bus
);

    rsp_state_e             state;
    logic                   long_q, crc_chk_q, idx_chk_q;
    logic [5:0]             idx_exp_q;
    logic [WaitCntWidth-1:0] wait_cnt;
    logic [7:0]             bit_cnt, cur_bit, last_bit, payload_last, crc_first;
    logic [PayloadBits-1:0] shift_q, rsp_q;
    logic [5:0]             idx_sh, rsp_idx_q;
    logic                   trans_q;
    logic [6:0]             rx_crc, crc_rem;
    logic                   rsp_valid_q, timeout_q, crc_err_q, end_err_q, idx_err_q;
    logic                   crc_en, crc_clr;
`ifdef RSP_BUSY_DETECT_EN
    logic                   busy_en_q, busy_q;
    logic [1:0]             busy_cnt;
`endif

    // Frame bit positions counted from the start bit (bit 0, first on the wire).
    assign last_bit     = long_q ? 8'(RspLongBits - 1) : 8'(RspShortBits - 1);
    assign payload_last = last_bit - 8'd8;
    assign crc_first    = long_q ? 8'(PayloadFirstBit) : 8'd0;
    assign crc_clr      = (state == ST_IDLE) && bus.start_i && !bus.abort_i;

    always_comb begin
        cur_bit = (state == ST_RECEIVE) ? bit_cnt : 8'd0;
        crc_en  = 1'b0;
        if (!bus.abort_i && ((state == ST_WAIT_START && !bus.cmd_i) || state == ST_RECEIVE)) begin
            crc_en = (cur_bit >= crc_first) && (cur_bit <= payload_last);
        end
    end

    sd_crc7_gen u_crc (
        .clk (sd_clk_i),
        .rst (rst_i),
        .clr (crc_clr),
        .en  (crc_en),
        .din (bus.cmd_i),
        .crc (crc_rem)
    );

    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            long_q      <= 1'b0;
            crc_chk_q   <= 1'b0;
            idx_chk_q   <= 1'b0;
            idx_exp_q   <= 6'd0;
            wait_cnt    <= '0;
            bit_cnt     <= 8'd0;
            shift_q     <= '0;
            idx_sh      <= 6'd0;
            trans_q     <= 1'b0;
            rx_crc      <= 7'd0;
            rsp_q       <= '0;
            rsp_idx_q   <= 6'd0;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            end_err_q   <= 1'b0;
            idx_err_q   <= 1'b0;
`ifdef RSP_BUSY_DETECT_EN
            busy_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            busy_cnt    <= 2'd0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            if (bus.abort_i) begin
                state <= ST_IDLE;
`ifdef RSP_BUSY_DETECT_EN
                busy_q <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start_i) begin
                            long_q    <= bus.long_rsp_i;
                            crc_chk_q <= bus.crc_check_en_i;
                            idx_chk_q <= bus.idx_check_en_i;
                            idx_exp_q <= bus.cmd_idx_i;
                            wait_cnt  <= '0;
                            bit_cnt   <= 8'd0;
                            shift_q   <= '0;
                            idx_sh    <= 6'd0;
                            trans_q   <= 1'b0;
                            rx_crc    <= 7'd0;
                            rsp_q     <= '0;
                            rsp_idx_q <= 6'd0;
                            timeout_q <= 1'b0;
                            crc_err_q <= 1'b0;
                            end_err_q <= 1'b0;
                            idx_err_q <= 1'b0;
`ifdef RSP_BUSY_DETECT_EN
                            busy_en_q <= bus.busy_en_i;
`endif
                            state     <= ST_WAIT_START;
                        end
                    end
                    ST_WAIT_START: begin
                        if (!bus.cmd_i) begin
                            bit_cnt <= 8'd1;
                            state   <= ST_RECEIVE;
                        end else if (wait_cnt == WaitCntWidth'(TimeoutCycles - 1)) begin
                            timeout_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + WaitCntWidth'(1);
                        end
                    end
                    ST_RECEIVE: begin
                        if (bit_cnt == 8'd1) trans_q <= bus.cmd_i;
                        if (bit_cnt >= 8'(IdxFirstBit) && bit_cnt < 8'(PayloadFirstBit))
                            idx_sh <= {idx_sh[4:0], bus.cmd_i};
                        if (bit_cnt >= 8'(PayloadFirstBit) && bit_cnt <= payload_last)
                            shift_q <= {shift_q[PayloadBits-2:0], bus.cmd_i};
                        if (bit_cnt > payload_last && bit_cnt < last_bit)
                            rx_crc <= {rx_crc[5:0], bus.cmd_i};
                        if (bit_cnt == last_bit) begin
                            rsp_valid_q <= 1'b1;
                            rsp_q       <= shift_q;
                            rsp_idx_q   <= idx_sh;
                            crc_err_q   <= crc_chk_q && (crc_rem != rx_crc);
                            end_err_q   <= !bus.cmd_i;
                            idx_err_q   <= idx_chk_q &&
                                           (trans_q || (idx_sh != (long_q ? 6'h3F : idx_exp_q)));
                            state       <= ST_IDLE;
`ifdef RSP_BUSY_DETECT_EN
                            if (busy_en_q) begin
                                state    <= ST_BUSY;
                                busy_q   <= 1'b1;
                                busy_cnt <= 2'd0;
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
`ifdef RSP_BUSY_DETECT_EN
                    // The card may not drive DAT0 low immediately, so its first two samples are ignored.
                    ST_BUSY: begin
                        if (busy_cnt != 2'd2) begin
                            busy_cnt <= busy_cnt + 2'd1;
                        end else if (bus.dat0_i) begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.receiving_o   = (state == ST_RECEIVE);
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_o         = rsp_q;
    assign bus.rsp_idx_o     = rsp_idx_q;
    assign bus.timeout_err_o = timeout_q;
    assign bus.crc_err_o     = crc_err_q;
    assign bus.end_bit_err_o = end_err_q;
    assign bus.idx_err_o     = idx_err_q;
    assign bus.state_o       = state;
`ifdef RSP_BUSY_DETECT_EN
    assign bus.busy_o        = busy_q;
`endif

endmodule

// File: tb/tb_rsp_receiver.sv
// Directed plus randomized bench for rsp_receiver; expected results come from a frame-level reference model.
module tb_rsp_receiver;
  import sd_rsp_pkg::*;

  localparam int TimeoutCycles = 64;
  localparam int W = 130;  // {rsp[119:0], idx[5:0], timeout, crc_err, end_bit_err, idx_err}

  logic sd_clk_i = 1'b0;
  logic rst_i;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  rsp_receiver_if bus();

  rsp_receiver #(.TimeoutCycles(TimeoutCycles)) dut (
    .sd_clk_i(sd_clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  // clock / watchdog
  always #5 sd_clk_i = ~sd_clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sd_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {bus.rsp_o, bus.rsp_idx_o, bus.timeout_err_o, bus.crc_err_o, bus.end_bit_err_o, bus.idx_err_o};
  endfunction

  // reference model: frame stored MSB-first, f[L-1] is the start bit
  function automatic logic [6:0] ref_crc(input logic [135:0] f, input int hi);
    logic [6:0] r;
    logic fb;
    r = 7'd0;
    for (int i = hi; i >= 8; i--) begin
      fb = f[i] ^ r[6];
      r = {r[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [135:0] f, input logic lng, input logic ce,
                                         input logic ie, input logic [5:0] cidx);
    int L;
    logic [119:0] pay;
    logic [5:0] idx;
    logic crc_bad, end_bad, idx_bad;
    L = lng ? 136 : 48;
    pay = lng ? f[127:8] : {88'd0, f[39:8]};
    idx = f[L-3 -: 6];
    crc_bad = ce && (ref_crc(f, lng ? 127 : 47) != f[7:1]);
    end_bad = !f[0];
    idx_bad = ie && (f[L-2] || idx != (lng ? 6'h3F : cidx));
    return {pay, idx, 1'b0, crc_bad, end_bad, idx_bad};
  endfunction

  function automatic logic [135:0] make_frame(input logic lng, input logic trans, input logic [5:0] idx,
                                              input logic [119:0] pay, input logic bad_crc, input logic endb);
    logic [135:0] f;
    logic [6:0] c;
    f = '0;
    if (lng) f[135:8] = {1'b0, trans, idx, pay};
    else     f[47:8]  = {1'b0, trans, idx, pay[31:0]};
    c = ref_crc(f, lng ? 127 : 47);
    if (bad_crc) c = c ^ 7'(1 << $urandom_range(0, 6));
    f[7:0] = {c, endb};
    return f;
  endfunction

  // driver: start, optional gap in WAIT_START, then the frame bit by bit; checks against exp_q
  task automatic run_frame(input logic [135:0] f, input logic lng, input logic ce, input logic ie,
                           input logic [5:0] cidx, input int gap, input string tag);
    int L;
    int early;
    logic rcv;
    L = lng ? 136 : 48;
    early = 0;
    bus.start_i = 1'b1;
    bus.long_rsp_i = lng;
    bus.crc_check_en_i = ce;
    bus.idx_check_en_i = ie;
    bus.cmd_idx_i = cidx;
    step();
    bus.start_i = 1'b0;
    bus.cmd_i = 1'b1;
    for (int g = 0; g < gap; g++) begin
      // start and config changes here must be ignored outside IDLE
      bus.start_i = 1'($urandom_range(0, 1));
      bus.long_rsp_i = ~lng;
      bus.crc_check_en_i = ~ce;
      bus.idx_check_en_i = ~ie;
      bus.cmd_idx_i = 6'($urandom);
      step();
      if (bus.rsp_valid_o) early++;
    end
    bus.start_i = 1'b0;
    rcv = 1'b0;
    for (int i = 0; i < L; i++) begin
      bus.cmd_i = f[L-1-i];
      step();
      if (i < L - 1 && bus.rsp_valid_o) early++;
      if (i == L - 2) rcv = bus.receiving_o;
    end
    chk({tag, " receiving"}, W'(rcv), W'(1));
    chk({tag, " early pulse"}, W'(early), W'(0));
    chk({tag, " valid"}, W'(bus.rsp_valid_o), W'(1));
    if (exp_q.size() > 0) chk({tag, " result"}, observed(), exp_q.pop_front());
    else chk({tag, " expected queue empty"}, W'(1), W'(0));
`ifdef RSP_BUSY_DETECT_EN
    chk({tag, " busy at end"}, W'(bus.busy_o), W'(bus.busy_en_i));
`endif
    bus.cmd_i = 1'b1;
    step();
    chk({tag, " valid drop"}, W'(bus.rsp_valid_o), W'(0));
  endtask

  initial begin
    logic [135:0] f;
    logic [135:0] r7;
    logic lng, ce, ie, trans, endb, bad;
    logic [5:0] idx, cidx;
    logic [119:0] pay;
    int cyc, pulses, hi;

    rst_i = 1'b1;
    bus.cmd_i = 1'b1;
    bus.start_i = 1'b0;
    bus.long_rsp_i = 1'b0;
    bus.crc_check_en_i = 1'b0;
    bus.idx_check_en_i = 1'b0;
    bus.cmd_idx_i = 6'd0;
    bus.abort_i = 1'b0;
`ifdef RSP_BUSY_DETECT_EN
    bus.busy_en_i = 1'b0;
    bus.dat0_i = 1'b1;
`endif
    repeat (3) step();
    rst_i = 1'b0;
    step();

    // reset state
    chk("reset results", observed(), W'(0));
    chk("reset valid", W'(bus.rsp_valid_o), W'(0));
    chk("reset receiving", W'(bus.receiving_o), W'(0));
    chk("reset state", W'(bus.state_o), W'(ST_IDLE));

    // R7 directed frames
    r7 = '0;
    r7[47:0] = 48'h08_000001AA_13;
    exp_q.push_back({120'h1AA, 6'd8, 4'b0000});
    run_frame(r7, 1'b0, 1'b1, 1'b1, 6'd8, 3, "r7 good");
    f = r7; f[7:0] = 8'h11;
    exp_q.push_back({120'h1AA, 6'd8, 4'b0100});
    run_frame(f, 1'b0, 1'b1, 1'b1, 6'd8, 0, "r7 crc");
    f = r7; f[7:0] = 8'h12;
    exp_q.push_back({120'h1AA, 6'd8, 4'b0010});
    run_frame(f, 1'b0, 1'b1, 1'b1, 6'd8, 1, "r7 end bit");
    exp_q.push_back({120'h1AA, 6'd8, 4'b0001});
    run_frame(r7, 1'b0, 1'b1, 1'b1, 6'd17, 2, "r7 idx");

    // R2 directed frames
    f = {8'h3F, 120'd0, 8'h01};
    exp_q.push_back({120'd0, 6'h3F, 4'b0000});
    run_frame(f, 1'b1, 1'b1, 1'b1, 6'd2, 2, "r2 good");
    f = {8'h3F, 120'd0, 8'h0B};
    exp_q.push_back({120'd0, 6'h3F, 4'b0000});
    run_frame(f, 1'b1, 1'b0, 1'b1, 6'd2, 0, "r2 crc masked");

    // Ncr timeout: start in cycle 0, pulse expected in cycle 65, exactly once
    bus.start_i = 1'b1;
    bus.long_rsp_i = 1'b0;
    step();
    bus.start_i = 1'b0;
    bus.cmd_i = 1'b1;
    cyc = 1;
    while (!bus.rsp_valid_o && cyc < 200) begin
      step();
      cyc++;
    end
    chk("timeout cycle", W'(cyc), W'(TimeoutCycles + 1));
    chk("timeout result", observed(), {120'd0, 6'd0, 4'b1000});
    pulses = 0;
    repeat (10) begin
      step();
      if (bus.rsp_valid_o) pulses++;
    end
    chk("timeout single pulse", W'(pulses), W'(0));
    chk("timeout state", W'(bus.state_o), W'(ST_IDLE));

    // abort at bit 20 of a short frame, then a clean retry
    bus.start_i = 1'b1;
    bus.crc_check_en_i = 1'b1;
    bus.idx_check_en_i = 1'b1;
    bus.cmd_idx_i = 6'd8;
    step();
    bus.start_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      bus.cmd_i = r7[47-i];
      bus.abort_i = (i == 20);
      step();
      if (i == 20) chk("abort receiving", W'(bus.receiving_o), W'(0));
      if (bus.rsp_valid_o) pulses++;
    end
    bus.abort_i = 1'b0;
    bus.cmd_i = 1'b1;
    chk("abort no pulse", W'(pulses), W'(0));
    exp_q.push_back({120'h1AA, 6'd8, 4'b0000});
    run_frame(r7, 1'b0, 1'b1, 1'b1, 6'd8, 0, "after abort");

    // start and abort together in IDLE: abort wins
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk("start+abort state", W'(bus.state_o), W'(ST_IDLE));
    pulses = 0;
    repeat (TimeoutCycles + 6) begin
      step();
      if (bus.rsp_valid_o) pulses++;
    end
    chk("start+abort no timeout", W'(pulses), W'(0));

    // randomized frames against the model
    for (int n = 0; n < 24; n++) begin
      lng = 1'($urandom_range(0, 1));
      trans = ($urandom_range(0, 7) == 0);
      idx = (lng && $urandom_range(0, 3) != 0) ? 6'h3F : 6'($urandom);
      pay = {$urandom, $urandom, $urandom, 24'($urandom)};
      bad = ($urandom_range(0, 3) == 0);
      endb = ($urandom_range(0, 7) != 0);
      ce = ($urandom_range(0, 3) != 0);
      ie = ($urandom_range(0, 3) != 0);
      cidx = ($urandom_range(0, 4) == 0) ? 6'($urandom) : idx;
      f = make_frame(lng, trans, idx, pay, bad, endb);
      exp_q.push_back(model(f, lng, ce, ie, cidx));
      run_frame(f, lng, ce, ie, cidx, $urandom_range(0, 10), $sformatf("rand%0d", n));
    end

    // reset in the middle of a long frame
    f = make_frame(1'b1, 1'b0, 6'h3F, {$urandom, $urandom, $urandom, 24'($urandom)}, 1'b0, 1'b1);
    bus.start_i = 1'b1;
    bus.long_rsp_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.cmd_i = f[135-i];
      step();
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("midreset results", observed(), W'(0));
    chk("midreset receiving", W'(bus.receiving_o), W'(0));
    pulses = 0;
    for (int i = 30; i < 136; i++) begin
      bus.cmd_i = f[135-i];
      step();
      if (bus.rsp_valid_o) pulses++;
    end
    bus.cmd_i = 1'b1;
    chk("midreset no pulse", W'(pulses), W'(0));

`ifdef RSP_BUSY_DETECT_EN
    // busy: DAT0 low for 10 cycles after the end bit
    bus.busy_en_i = 1'b1;
    bus.dat0_i = 1'b0;
    exp_q.push_back({120'h1AA, 6'd8, 4'b0000});
    run_frame(r7, 1'b0, 1'b1, 1'b1, 6'd8, 0, "busy frame");
    hi = 1;  // first busy cycle is the one after the end bit, read in run_frame's drop check
    if (!bus.busy_o) hi = 0;
    for (int k = 2; k <= 9; k++) begin
      step();
      if (bus.busy_o) hi++;
    end
    bus.dat0_i = 1'b1;
    step();
    chk("busy high cycles", W'(hi), W'(9));
    chk("busy release", W'(bus.busy_o), W'(0));
    chk("busy exit state", W'(bus.state_o), W'(ST_IDLE));
    bus.dat0_i = 1'b0;
    exp_q.push_back({120'h1AA, 6'd8, 4'b0000});
    run_frame(r7, 1'b0, 1'b1, 1'b1, 6'd8, 0, "busy reset frame");
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("busy reset busy", W'(bus.busy_o), W'(0));
    chk("busy reset results", observed(), W'(0));
    chk("busy reset state", W'(bus.state_o), W'(ST_IDLE));
    bus.busy_en_i = 1'b0;
    bus.dat0_i = 1'b1;
`endif

    chk("expected queue drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
